regfile_bank_param: RTL and testbench
=====================================

# regfile_bank_param

Parametrised, clocked successor to the 16×32 register bank: a DEPTH×DATA_W register file with one synchronous write port, two asynchronous read ports, optional write-to-read bypass, an optional hardwired zero register, and a per-register busy scoreboard. It sits between decode (reads, reservations) and writeback (writes) of the 32-bit datapath. Per read port it reports whether the returned operand is valid or still awaiting a producer.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads see stored value only
- ZERO_REG, 0, 1 = register 0 reads as 0 and ignores writes and reservations

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rsv_en  in  1  reserve strobe: mark register busy (producer in flight)
- rsv_addr  in  ADDR_W  register to reserve
- rd_addr_a  in  ADDR_W  read port A address
- rd_addr_b  in  ADDR_W  read port B address
- rd_data_a  out  DATA_W  read port A data
- rd_data_b  out  DATA_W  read port B data
- rd_rdy_a  out  1  port A operand valid (not pending)
- rd_rdy_b  out  1  port B operand valid (not pending)

## Operation
- Storage: DEPTH registers of DATA_W bits, plus one busy bit per register.
- Write: on rising clk with wr_en=1, mem[wr_addr] <= wr_data and busy[wr_addr] <= 0.
- Reserve: on rising clk with rsv_en=1, busy[rsv_addr] <= 1.
- Write and reserve to the same address in one cycle: data is stored and busy ends at 1. The reservation belongs to a newer producer and wins.
- Write and reserve to different addresses: both take effect independently.
- Read, per port p, combinational:
  - If BYPASS=1, wr_en=1 and rd_addr_p==wr_addr: rd_data_p = wr_data and rd_rdy_p = 1.
  - Otherwise: rd_data_p = mem[rd_addr_p] and rd_rdy_p = ~busy[rd_addr_p].
- Bypass ignores a same-cycle reservation of the read address. The reservation affects the next cycle only.
- With BYPASS=0, a read of the register being written returns the old value, and rd_rdy reflects the old busy bit.
- ZERO_REG=1: reads of address 0 return 0 with rdy=1, including under bypass. Writes and reservations to address 0 are dropped.
- Both ports may read the same address and return identical results.

## Timing
- Reset (async assert, sampled release): every mem entry is 0 and every busy bit is 0. With inputs idle, rd_data_a/b = 0 and rd_rdy_a/b = 1 immediately on assertion, no clock needed.
- Reset mid-operation: pending reservations are discarded. A wr_en or rsv_en coincident with the rst assertion edge has no effect.
- Write latency:
  - 1 cycle to storage.
  - 0 cycles to the read ports when BYPASS=1.
  - Visible from the next cycle when BYPASS=0.
- Reserve latency: rd_rdy drops starting the cycle after rsv_en.
- No backpressure. Every strobe is accepted every cycle, and there is no full/empty condition.
- Address wrap: all ADDR_W-bit values are legal, so there are no out-of-range addresses.

## Structure
- Shared package `regfile_pkg`: default DATA_W/ADDR_W localparams and the zero-register address constant.
- Sub-module `regfile_scoreboard`:
  - Holds the DEPTH busy bits, with set/clear priority (set wins) and async reset.
  - Exposes busy[] to the top.
  - The top owns storage, bypass muxing and ZERO_REG masking.
- Target 150–250 lines of RTL total.

## Test plan
- Reset: assert rst with no clock edge, then sample every address on both ports. Required: data 0 and rdy 1 for all 16 addresses.
- Fill/readback (defaults): write reg k = 10+k for k=0..15, one per cycle, then read A=k, B=15−k. Required: A returns 10+k, B returns 25−k, both rdy=1.
- Bypass: BYPASS=1, write reg 5 = 0xDEADBEEF while rd_addr_a=5 in the same cycle. Required: rd_data_a=0xDEADBEEF that cycle. With BYPASS=0, the same stimulus returns the old value 15 and shows the new value the next cycle.
- Scoreboard: reserve reg 7, then read reg 7 for 3 idle cycles. Required: rdy_a=0. Then write 97: rdy=1 with data 97 in the write cycle (bypass) and thereafter.
- Collision: write reg 3 = 13 and reserve reg 3 in the same cycle. Required next cycle: data 13, rdy=0.
- Zero register and reset mid-op: with ZERO_REG=1, write reg 0 = 44 and reserve reg 0. Required: reads 0, rdy=1. Then reserve reg 9 and pulse rst. Required: reg 9 reads 0 with rdy=1.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and constants for the parametrised register bank.
package regfile_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 4;
    localparam int ZERO_ADDR  = 0;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: reserve sets, writeback clears, and a reserve to
// the same register in the same cycle wins over the clear.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    output logic [DEPTH-1:0]  busy
);

    logic [DEPTH-1:0] r_busy;

    // The set comes last so that a newer producer's reservation survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            if (clr_en) begin
                r_busy[clr_addr] <= 1'b0;
            end
            if (set_en) begin
                r_busy[set_addr] <= 1'b1;
            end
        end
    end

    assign busy = r_busy;

endmodule

// File: rtl/regfile_bank_param.sv
// DEPTH x DATA_W register file with one write port, two async read ports,
// optional write-to-read bypass, optional zero register and busy scoreboard.
module regfile_bank_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_rdy_a,
    output logic              rd_rdy_b
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_ADDR);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  w_busy;
    logic              w_wrOk;
    logic              w_rsvOk;
    logic [ADDR_W-1:0] w_rdAddr [2];
    logic [DATA_W-1:0] w_rdData [2];
    logic              w_rdRdy  [2];

    function automatic logic isZeroAddr(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == ZERO_IDX);
    endfunction

    assign w_wrOk  = wr_en  && !isZeroAddr(wr_addr);
    assign w_rsvOk = rsv_en && !isZeroAddr(rsv_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wrOk) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (w_rsvOk),
        .set_addr (rsv_addr),
        .clr_en   (w_wrOk),
        .clr_addr (wr_addr),
        .busy     (w_busy)
    );

    assign w_rdAddr[0] = rd_addr_a;
    assign w_rdAddr[1] = rd_addr_b;

    // Bypass ignores a same-cycle reservation; the zero mask overrides everything.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rdData[p] = r_mem[w_rdAddr[p]];
            w_rdRdy[p]  = ~w_busy[w_rdAddr[p]];
            if ((BYPASS != 0) && w_wrOk && (w_rdAddr[p] == wr_addr)) begin
                w_rdData[p] = wr_data;
                w_rdRdy[p]  = 1'b1;
            end
            if (isZeroAddr(w_rdAddr[p])) begin
                w_rdData[p] = '0;
                w_rdRdy[p]  = 1'b1;
            end
        end
    end

    assign rd_data_a = w_rdData[0];
    assign rd_data_b = w_rdData[1];
    assign rd_rdy_a  = w_rdRdy[0];
    assign rd_rdy_b  = w_rdRdy[1];

endmodule

// File: tb/tb_regfile_bank_param.sv
// Directed bench driving three configurations of the register bank
// (bypass, no bypass, bypass with zero register) from shared stimulus.
module tb_regfile_bank_param;

    typedef struct {
        logic [3:0]  addrA;
        logic [3:0]  addrB;
        logic [31:0] expA;
        logic [31:0] expB;
        logic        expRdyA;
        logic        expRdyB;
    } readVec_t;

    logic        clk;
    logic        rst;
    logic        wrEn;
    logic [3:0]  wrAddr;
    logic [31:0] wrData;
    logic        rsvEn;
    logic [3:0]  rsvAddr;
    logic [3:0]  rdAddrA;
    logic [3:0]  rdAddrB;

    logic [31:0] bpDataA, bpDataB, nbDataA, nbDataB, zrDataA, zrDataB;
    logic        bpRdyA, bpRdyB, nbRdyA, nbRdyB, zrRdyA, zrRdyB;

    int checkCount;
    int passCount;

    readVec_t resetTable [16];
    readVec_t fillTable  [16];

    regfile_bank_param #(.DATA_W(32), .ADDR_W(4), .BYPASS(1), .ZERO_REG(0)) dutBp (
        .clk(clk), .rst(rst), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
        .rsv_en(rsvEn), .rsv_addr(rsvAddr), .rd_addr_a(rdAddrA), .rd_addr_b(rdAddrB),
        .rd_data_a(bpDataA), .rd_data_b(bpDataB), .rd_rdy_a(bpRdyA), .rd_rdy_b(bpRdyB)
    );

    regfile_bank_param #(.DATA_W(32), .ADDR_W(4), .BYPASS(0), .ZERO_REG(0)) dutNb (
        .clk(clk), .rst(rst), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
        .rsv_en(rsvEn), .rsv_addr(rsvAddr), .rd_addr_a(rdAddrA), .rd_addr_b(rdAddrB),
        .rd_data_a(nbDataA), .rd_data_b(nbDataB), .rd_rdy_a(nbRdyA), .rd_rdy_b(nbRdyB)
    );

    regfile_bank_param #(.DATA_W(32), .ADDR_W(4), .BYPASS(1), .ZERO_REG(1)) dutZr (
        .clk(clk), .rst(rst), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
        .rsv_en(rsvEn), .rsv_addr(rsvAddr), .rd_addr_a(rdAddrA), .rd_addr_b(rdAddrB),
        .rd_data_a(zrDataA), .rd_data_b(zrDataB), .rd_rdy_a(zrRdyA), .rd_rdy_b(zrRdyB)
    );

    // Long period so a full 16-address sweep fits inside one low phase.
    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Drive every input at once, then let the combinational read paths settle.
    task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                                 input logic re, input logic [3:0] ra,
                                 input logic [3:0] aa, input logic [3:0] ab);
        wrEn    = we;
        wrAddr  = wa;
        wrData  = wd;
        rsvEn   = re;
        rsvAddr = ra;
        rdAddrA = aa;
        rdAddrB = ab;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end else begin
            passCount++;
        end
    endtask

    // Compare the bypass instance's two ports against one table record.
    task automatic checkVec(input string tag, input readVec_t v);
        checkOutput({tag, " dataA"}, bpDataA, v.expA);
        checkOutput({tag, " dataB"}, bpDataB, v.expB);
        checkOutput({tag, " rdyA"}, 32'(bpRdyA), 32'(v.expRdyA));
        checkOutput({tag, " rdyB"}, 32'(bpRdyB), 32'(v.expRdyB));
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        rst        = 1'b0;
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0, 4'd0);

        for (int k = 0; k < 16; k++) begin
            resetTable[k] = '{addrA: 4'(k), addrB: 4'(15 - k), expA: 32'd0, expB: 32'd0,
                              expRdyA: 1'b1, expRdyB: 1'b1};
            fillTable[k]  = '{addrA: 4'(k), addrB: 4'(15 - k), expA: 32'(10 + k),
                              expB: 32'(25 - k), expRdyA: 1'b1, expRdyB: 1'b1};
        end

        // Reset asserted in the low phase; all reads must clear before any edge.
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, resetTable[k].addrA, resetTable[k].addrB);
            checkVec("reset", resetTable[k]);
        end
        @(negedge clk);
        rst = 1'b0;

        // Fill reg k with 10+k, then read back crosswise.
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b1, 4'(k), 32'(10 + k), 1'b0, 4'd0, 4'd0, 4'd0);
            @(negedge clk);
        end
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, fillTable[k].addrA, fillTable[k].addrB);
            checkVec("fill", fillTable[k]);
            checkOutput("fill nb dataA", nbDataA, fillTable[k].expA);
        end

        // Same-cycle write: bypass forwards, no-bypass shows old value until next cycle.
        @(negedge clk);
        applyStimulus(1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 4'd5, 4'd6);
        checkOutput("bypass bp dataA", bpDataA, 32'hDEADBEEF);
        checkOutput("bypass bp rdyA", 32'(bpRdyA), 32'd1);
        checkOutput("bypass nb old dataA", nbDataA, 32'd15);
        checkOutput("bypass bp dataB", bpDataB, 32'd16);
        @(negedge clk);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd5, 4'd6);
        checkOutput("bypass nb new dataA", nbDataA, 32'hDEADBEEF);

        // Reserve reg 7: ready stays high in the reserve cycle, drops after.
        @(negedge clk);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd7, 4'd7, 4'd8);
        checkOutput("rsv same-cycle rdyA", 32'(bpRdyA), 32'd1);
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd7, 4'd8);
            checkOutput("rsv pending bp rdyA", 32'(bpRdyA), 32'd0);
            checkOutput("rsv pending nb rdyA", 32'(nbRdyA), 32'd0);
            checkOutput("rsv other rdyB", 32'(bpRdyB), 32'd1);
            @(negedge clk);
        end
        applyStimulus(1'b1, 4'd7, 32'd97, 1'b0, 4'd0, 4'd7, 4'd8);
        checkOutput("wb bypass dataA", bpDataA, 32'd97);
        checkOutput("wb bypass rdyA", 32'(bpRdyA), 32'd1);
        checkOutput("wb nb old dataA", nbDataA, 32'd17);
        checkOutput("wb nb old rdyA", 32'(nbRdyA), 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd7, 4'd7);
        checkOutput("wb after bp dataA", bpDataA, 32'd97);
        checkOutput("wb after bp rdyA", 32'(bpRdyA), 32'd1);
        checkOutput("wb after nb rdyB", 32'(nbRdyB), 32'd1);
        checkOutput("wb after nb dataB", nbDataB, 32'd97);

        // Write and reserve reg 3 together: data lands, busy survives.
        @(negedge clk);
        applyStimulus(1'b1, 4'd3, 32'd13, 1'b1, 4'd3, 4'd3, 4'd3);
        checkOutput("collide bypass rdyA", 32'(bpRdyA), 32'd1);
        @(negedge clk);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd3, 4'd3);
        checkOutput("collide dataA", bpDataA, 32'd13);
        checkOutput("collide rdyA", 32'(bpRdyA), 32'd0);
        checkOutput("collide dataB", bpDataB, 32'd13);
        checkOutput("collide rdyB", 32'(bpRdyB), 32'd0);
        checkOutput("collide nb rdyA", 32'(nbRdyA), 32'd0);

        // Zero register drops write and reservation, even under bypass.
        @(negedge clk);
        applyStimulus(1'b1, 4'd0, 32'd44, 1'b1, 4'd0, 4'd0, 4'd0);
        checkOutput("zero bypass dataA", zrDataA, 32'd0);
        checkOutput("zero bypass rdyA", 32'(zrRdyA), 32'd1);
        @(negedge clk);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0, 4'd0);
        checkOutput("zero dataA", zrDataA, 32'd0);
        checkOutput("zero rdyA", 32'(zrRdyA), 32'd1);
        checkOutput("zero dataB", zrDataB, 32'd0);
        checkOutput("zero rdyB", 32'(zrRdyB), 32'd1);
        checkOutput("nonzero reg0 data", bpDataA, 32'd44);
        checkOutput("nonzero reg0 rdy", 32'(bpRdyA), 32'd0);

        // Reserve reg 9, then reset mid-operation.
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd9, 4'd9, 4'd9);
        @(negedge clk);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd9, 4'd9);
        checkOutput("pre-reset rdy9", 32'(bpRdyA), 32'd0);
        checkOutput("pre-reset data9", bpDataA, 32'd19);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst data9", bpDataA, 32'd0);
        checkOutput("midrst rdy9", 32'(bpRdyA), 32'd1);
        checkOutput("midrst zr rdy9", 32'(zrRdyB), 32'd1);
        // Strobes while reset is held must be discarded.
        @(negedge clk);
        applyStimulus(1'b1, 4'd9, 32'd55, 1'b1, 4'd9, 4'd2, 4'd2);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd9, 4'd7);
        checkOutput("postrst data9", bpDataA, 32'd0);
        checkOutput("postrst rdy9", 32'(bpRdyA), 32'd1);
        checkOutput("postrst nb data9", nbDataA, 32'd0);
        checkOutput("postrst data7", bpDataB, 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
